// File: rtl/vga_mem_pkg.sv
// ---------------------------------------------------------------------------
// vga_mem_pkg
// Shared constants and types for the VGA memory-fetch path.
//   ADDR_W / DATA_W / BURST_W : SDRAM Avalon-MM bus geometry
//   arb_state_t               : burst arbiter states (IDLE, ISSUE, DATA)
//   PORT0 / PORT1             : port indices (background / sprite fetcher)
//   cnt_width()               : bit width needed to hold 0..max_val
// ---------------------------------------------------------------------------
package vga_mem_pkg;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 16;
    localparam int BURST_W = 5;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner select for the two-port SDRAM read arbiter.
// Ports:
//   i_req0, i_req1 : read requests from port 0 / port 1
//   i_urgent       : port-0 line FIFO is below its refill threshold
//   i_consec       : back-to-back port-0 grants taken while port 1 waited
//   i_last_grant   : owner of the most recently completed burst
//   o_valid        : at least one port is requesting
//   o_grant        : winning port index (meaningful only when o_valid)
// ---------------------------------------------------------------------------
module arb_pick
    import vga_mem_pkg::*;
#(
    parameter int M0_MAX_CONSEC = 4,
    parameter int CNT_W         = 3
) (
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic             i_urgent,
    input  logic [CNT_W-1:0] i_consec,
    input  logic             i_last_grant,
    output logic             o_valid,
    output logic             o_grant
);

    localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(M0_MAX_CONSEC);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = PORT0;
        if (i_req0 && !i_req1) begin
            o_grant = PORT0;
        end else if (!i_req0 && i_req1) begin
            o_grant = PORT1;
        end else if (i_req0 && i_req1) begin
            // Urgent background refill may jump the queue, but only until
            // the cap is reached; after that plain round-robin lets the
            // sprite fetcher through.
            if (i_urgent && (i_consec < CONSEC_MAX)) begin
                o_grant = PORT0;
            end else begin
                o_grant = ~i_last_grant;
            end
        end
    end

endmodule

// File: rtl/sdram_read_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_read_arbiter
// Shares one SDRAM Avalon-MM burst-read master port between the VGA
// background fetcher (port 0) and the sprite fetcher (port 1). One burst is
// outstanding at a time: the winner's command is latched in IDLE, presented
// in ISSUE until the SDRAM accepts it, and its read beats are steered back
// to the owner in DATA.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   mN_read/address/burstcount      : burst read request from port N
//   m0_urgent                       : port-0 FIFO low, favour port 0
//   mN_waitrequest                  : low only in the cycle N is accepted
//   mN_readdatavalid / mN_readdata  : read beats routed to port N
//   sd_read/chipselect/begin...     : command strobes to SDRAM controller
//   sd_address/burstcount/byteenable: command fields to SDRAM controller
//   sd_waitrequest/readdatavalid/readdata : responses from SDRAM controller
// ---------------------------------------------------------------------------
module sdram_read_arbiter
    import vga_mem_pkg::*;
#(
    parameter int M0_MAX_CONSEC = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               m0_read,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_urgent,
    output logic               m0_waitrequest,
    output logic               m0_readdatavalid,
    output logic [DATA_W-1:0]  m0_readdata,

    input  logic               m1_read,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    output logic               m1_waitrequest,
    output logic               m1_readdatavalid,
    output logic [DATA_W-1:0]  m1_readdata,

    output logic               sd_read,
    output logic               sd_chipselect,
    output logic               sd_beginbursttransfer,
    output logic [ADDR_W-1:0]  sd_address,
    output logic [BURST_W-1:0] sd_burstcount,
    output logic [1:0]         sd_byteenable,
    input  logic               sd_waitrequest,
    input  logic               sd_readdatavalid,
    input  logic [DATA_W-1:0]  sd_readdata
);

    localparam int               CNT_W      = cnt_width(M0_MAX_CONSEC);
    localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(M0_MAX_CONSEC);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               r_grant;
    logic               r_last_grant;
    logic               r_first;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0]   r_consec;

    logic               w_pick_valid;
    logic               w_pick_grant;
    logic [BURST_W-1:0] w_sel_burst;
    logic [ADDR_W-1:0]  w_sel_addr;

    // A zero burstcount still moves one beat.
    function automatic logic [BURST_W-1:0] norm_burst(input logic [BURST_W-1:0] b);
        return (b == '0) ? BURST_W'(1) : b;
    endfunction

    arb_pick #(
        .M0_MAX_CONSEC (M0_MAX_CONSEC),
        .CNT_W         (CNT_W)
    ) u_pick (
        .i_req0       (m0_read),
        .i_req1       (m1_read),
        .i_urgent     (m0_urgent),
        .i_consec     (r_consec),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    assign w_sel_addr  = (w_pick_grant == PORT1) ? m1_address : m0_address;
    assign w_sel_burst = (w_pick_grant == PORT1) ? m1_burstcount : m0_burstcount;

    // Command fields come straight from the latches so they stay stable for
    // the whole time the SDRAM holds waitrequest.
    assign sd_address    = r_addr;
    assign sd_burstcount = r_burst;
    assign sd_byteenable = 2'b11;

    // Read data is broadcast; only the owner's valid is raised.
    assign m0_readdata = sd_readdata;
    assign m1_readdata = sd_readdata;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and command/response strobes.
    always_comb begin
        w_state_nxt           = r_state;
        sd_read               = 1'b0;
        sd_chipselect         = 1'b0;
        sd_beginbursttransfer = 1'b0;
        m0_waitrequest        = 1'b1;
        m1_waitrequest        = 1'b1;
        m0_readdatavalid      = 1'b0;
        m1_readdatavalid      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                sd_read               = 1'b1;
                sd_chipselect         = 1'b1;
                sd_beginbursttransfer = r_first;
                if (!sd_waitrequest) begin
                    w_state_nxt = DATA;
                    if (r_grant == PORT0) begin
                        m0_waitrequest = 1'b0;
                    end else begin
                        m1_waitrequest = 1'b0;
                    end
                end
            end
            DATA: begin
                // Beats arriving in any other state are simply not forwarded.
                if (sd_readdatavalid) begin
                    if (r_grant == PORT0) begin
                        m0_readdatavalid = 1'b1;
                    end else begin
                        m1_readdatavalid = 1'b1;
                    end
                    if (r_beat_cnt == BURST_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant, command latches, fairness counter and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= PORT0;
            r_last_grant <= PORT1;
            r_first      <= 1'b0;
            r_addr       <= '0;
            r_burst      <= '0;
            r_beat_cnt   <= '0;
            r_consec     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_grant;
                        r_addr  <= w_sel_addr;
                        r_burst <= norm_burst(w_sel_burst);
                        r_first <= 1'b1;
                        // Only grants taken while port 1 waits count toward
                        // the cap; an uncontested port-0 grant restarts at 1.
                        if (w_pick_grant == PORT1) begin
                            r_consec <= '0;
                        end else if (!m1_read) begin
                            r_consec <= CNT_W'(1);
                        end else if (r_consec < CONSEC_MAX) begin
                            r_consec <= r_consec + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    r_first <= 1'b0;
                    if (!sd_waitrequest) begin
                        r_beat_cnt <= r_burst;
                    end
                end
                DATA: begin
                    if (sd_readdatavalid) begin
                        r_beat_cnt <= r_beat_cnt - BURST_W'(1);
                        if (r_beat_cnt == BURST_W'(1)) begin
                            r_last_grant <= r_grant;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
module tb_sdram_read_arbiter;
    import vga_mem_pkg::*;

    localparam int MAXC = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               m0_read, m1_read, m0_urgent;
    logic [ADDR_W-1:0]  m0_address, m1_address;
    logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
    logic               m0_waitrequest, m1_waitrequest;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic [DATA_W-1:0]  m0_readdata, m1_readdata;
    logic               sd_read, sd_chipselect, sd_beginbursttransfer;
    logic [ADDR_W-1:0]  sd_address;
    logic [BURST_W-1:0] sd_burstcount;
    logic [1:0]         sd_byteenable;
    logic               sd_waitrequest, sd_readdatavalid;
    logic [DATA_W-1:0]  sd_readdata;

    // SDRAM responses come either from the slave model or from directed code.
    logic               s_wait, s_rdv, t_wait, t_rdv;
    logic [DATA_W-1:0]  s_data, t_data;
    bit                 slave_en = 1'b0;
    bit                 mon_en   = 1'b0;
    int                 fixed_delay = -1;

    assign sd_waitrequest   = slave_en ? s_wait : t_wait;
    assign sd_readdatavalid = slave_en ? s_rdv  : t_rdv;
    assign sd_readdata      = slave_en ? s_data : t_data;

    always #5 clk = ~clk;

    sdram_read_arbiter #(.M0_MAX_CONSEC(MAXC)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_address(m0_address), .m0_burstcount(m0_burstcount),
        .m0_urgent(m0_urgent), .m0_waitrequest(m0_waitrequest),
        .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_address(m1_address), .m1_burstcount(m1_burstcount),
        .m1_waitrequest(m1_waitrequest),
        .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
        .sd_read(sd_read), .sd_chipselect(sd_chipselect),
        .sd_beginbursttransfer(sd_beginbursttransfer),
        .sd_address(sd_address), .sd_burstcount(sd_burstcount),
        .sd_byteenable(sd_byteenable), .sd_waitrequest(sd_waitrequest),
        .sd_readdatavalid(sd_readdatavalid), .sd_readdata(sd_readdata)
    );

    typedef struct { logic [ADDR_W-1:0] addr; logic [BURST_W-1:0] burst; } item_t;
    typedef struct { int port; logic [ADDR_W-1:0] addr; logic [BURST_W-1:0] burst; } cmd_t;
    typedef struct { int port; logic [DATA_W-1:0] data; } beat_t;

    item_t items0[$];
    item_t items1[$];
    cmd_t  exp_cmd[$];
    beat_t exp_beat[$];

    int n_tests = 0;
    int n_fail  = 0;
    int m_consec;   // reference fairness state
    int m_last;

    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a, input int k);
        logic [DATA_W-1:0] r;
        r = a[DATA_W-1:0] ^ 16'hA5C3;
        return r + DATA_W'(k * 257);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: both masters keep requesting while they still
    // have items, so each decision depends only on remaining item counts.
    task automatic model_phase(input bit urg);
        int c0, c1, i0, i1, p, nb;
        item_t it;
        c0 = items0.size(); c1 = items1.size(); i0 = 0; i1 = 0;
        while (c0 > 0 || c1 > 0) begin
            if (c1 == 0)                     p = 0;
            else if (c0 == 0)                p = 1;
            else if (urg && m_consec < MAXC) p = 0;
            else                             p = 1 - m_last;
            if (p == 0) begin
                m_consec = (c1 > 0) ? ((m_consec < MAXC) ? m_consec + 1 : MAXC) : 1;
                it = items0[i0]; i0++; c0--;
            end else begin
                m_consec = 0;
                it = items1[i1]; i1++; c1--;
            end
            m_last = p;
            nb = (it.burst == 0) ? 1 : int'(it.burst);
            exp_cmd.push_back('{p, it.addr, BURST_W'(nb)});
            for (int k = 0; k < nb; k++) exp_beat.push_back('{p, exp_data(it.addr, k)});
        end
    endtask

    task automatic drive(input int p);
        item_t it;
        int    cnt;
        bit    acc;
        while ((p == 0) ? (items0.size() > 0) : (items1.size() > 0)) begin
            if (p == 0) begin
                it = items0.pop_front();
                m0_read = 1'b1; m0_address = it.addr; m0_burstcount = it.burst;
            end else begin
                it = items1.pop_front();
                m1_read = 1'b1; m1_address = it.addr; m1_burstcount = it.burst;
            end
            acc = 1'b0; cnt = 0;
            while (!acc && cnt < 3000) begin
                @(negedge clk);
                acc = (p == 0) ? !m0_waitrequest : !m1_waitrequest;
                cnt++;
            end
            @(posedge clk); #1;
            if (!acc) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout port %0d: no acceptance within %0d cycles", p, cnt);
                if (p == 0) items0.delete(); else items1.delete();
            end
        end
        if (p == 0) m0_read = 1'b0; else m1_read = 1'b0;
    endtask

    task automatic run_phase(input bit urg);
        int cnt;
        m0_urgent = urg;
        model_phase(urg);
        @(posedge clk); #1;
        fork
            drive(0);
            drive(1);
        join
        cnt = 0;
        while ((exp_cmd.size() > 0 || exp_beat.size() > 0) && cnt < 5000) begin
            @(negedge clk); cnt++;
        end
        check("drain_cmds_left", 64'(exp_cmd.size()), 64'd0);
        check("drain_beats_left", 64'(exp_beat.size()), 64'd0);
        exp_cmd.delete(); exp_beat.delete();
        repeat (2) @(posedge clk); #1;
    endtask

    // SDRAM slave model: random accept delay, random gaps between beats.
    initial begin
        int d, gap, n;
        logic [ADDR_W-1:0] a;
        s_wait = 1'b1; s_rdv = 1'b0; s_data = '0;
        forever begin
            @(posedge clk); #1;
            if (slave_en && sd_read) begin
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                repeat (d) begin @(posedge clk); #1; end
                s_wait = 1'b0; a = sd_address; n = int'(sd_burstcount);
                @(posedge clk); #1;
                s_wait = 1'b1;
                for (int k = 0; k < n; k++) begin
                    gap = int'($urandom_range(0, 2));
                    repeat (gap) begin @(posedge clk); #1; end
                    s_rdv = 1'b1; s_data = exp_data(a, k);
                    @(posedge clk); #1;
                    s_rdv = 1'b0; s_data = DATA_W'($urandom);
                end
            end
        end
    end

    // Monitor: pops expected commands and beats as the DUT presents them.
    cmd_t cur;
    bit   have_cur = 1'b0;
    bit   prev_wait = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        int    ap;
        if (!mon_en) begin
            prev_wait = 1'b0;
        end else begin
            if (sd_read && !prev_wait) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", 64'(sd_address), 64'hFFFF_FFFF);
                end else begin
                    cur = exp_cmd.pop_front(); have_cur = 1'b1;
                    check("begin_first", 64'(sd_beginbursttransfer), 64'd1);
                end
            end else begin
                check("begin_not_first", 64'(sd_beginbursttransfer), 64'd0);
            end
            if (sd_read && have_cur) begin
                check("cmd_addr", 64'(sd_address), 64'(cur.addr));
                check("cmd_burst", 64'(sd_burstcount), 64'(cur.burst));
                check("cmd_cs_be", {sd_chipselect, sd_byteenable}, 64'h7);
            end
            check("m0_waitrequest", 64'(m0_waitrequest),
                  64'(!(sd_read && !sd_waitrequest && have_cur && cur.port == 0)));
            check("m1_waitrequest", 64'(m1_waitrequest),
                  64'(!(sd_read && !sd_waitrequest && have_cur && cur.port == 1)));
            prev_wait = sd_read && sd_waitrequest;
            if (m0_readdatavalid || m1_readdatavalid) begin
                ap = m1_readdatavalid ? 1 : 0;
                if (m0_readdatavalid && m1_readdatavalid) begin
                    check("both_valid", 64'd1, 64'd0);
                end else if (exp_beat.size() == 0) begin
                    check("unexpected_beat_port", 64'(ap), 64'hFF);
                end else begin
                    b = exp_beat.pop_front();
                    check("beat_port", 64'(ap), 64'(b.port));
                    check("beat_data", 64'(ap ? m1_readdata : m0_readdata), 64'(b.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        m0_read = 1'b0; m1_read = 1'b0; m0_urgent = 1'b0;
        m0_address = '0; m1_address = '0; m0_burstcount = '0; m1_burstcount = '0;
        t_wait = 1'b1; t_rdv = 1'b0; t_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sd_strobes", {sd_read, sd_chipselect, sd_beginbursttransfer}, 64'd0);
        check("rst_sd_address", 64'(sd_address), 64'd0);
        check("rst_sd_burst", 64'(sd_burstcount), 64'd0);
        check("rst_byteenable", 64'(sd_byteenable), 64'd3);
        check("rst_waitrequests", {m0_waitrequest, m1_waitrequest}, 64'd3);
        check("rst_valids", {m0_readdatavalid, m1_readdatavalid}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1; m_consec = 0;
        mon_en = 1'b1; slave_en = 1'b1;

        // Port 1 alone.
        items1.push_back('{ADDR_W'(32'h100), BURST_W'(8)});
        run_phase(1'b0);

        // Both requesting, no urgency: alternate.
        for (int i = 0; i < 2; i++) begin
            items0.push_back('{ADDR_W'(32'h1000 + i * 64), BURST_W'(8)});
            items1.push_back('{ADDR_W'(32'h2000 + i * 64), BURST_W'(8)});
        end
        run_phase(1'b0);

        // Both requesting, port 0 urgent: capped runs of port-0 grants.
        for (int i = 0; i < 8; i++) items0.push_back('{ADDR_W'(32'h3000 + i * 16), BURST_W'(2)});
        for (int i = 0; i < 2; i++) items1.push_back('{ADDR_W'(32'h4000 + i * 16), BURST_W'(2)});
        run_phase(1'b1);

        // Long SDRAM stall in ISSUE.
        fixed_delay = 5;
        items0.push_back('{ADDR_W'(32'h5000), BURST_W'(4)});
        run_phase(1'b0);
        fixed_delay = -1;

        // Zero burstcount moves one beat.
        items0.push_back('{ADDR_W'(32'h6000), BURST_W'(0)});
        run_phase(1'b0);

        // Reset in the middle of a burst, then stray beats.
        mon_en = 1'b0; slave_en = 1'b0;
        m1_read = 1'b1; m1_address = ADDR_W'(32'h200); m1_burstcount = BURST_W'(8);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!sd_read && cnt < 20);
        check("rr_cmd_seen", 64'(sd_read), 64'd1);
        check("rr_cmd_addr", 64'(sd_address), 64'h200);
        @(posedge clk); #1; t_wait = 1'b0;
        @(negedge clk);
        check("rr_accept", 64'(m1_waitrequest), 64'd0);
        @(posedge clk); #1; t_wait = 1'b1; m1_read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t_rdv = 1'b1; t_data = exp_data(ADDR_W'(32'h200), k);
            @(negedge clk);
            check("rr_beat_fwd", {m0_readdatavalid, m1_readdatavalid, m1_readdata}, {2'b01, t_data});
            @(posedge clk); #1;
        end
        t_rdv = 1'b1; reset = 1'b1;
        #1;
        check("rr_rst_strobes", {sd_read, sd_chipselect, sd_beginbursttransfer}, 64'd0);
        check("rr_rst_fields", {sd_address, sd_burstcount}, 64'd0);
        check("rr_rst_wait", {m0_waitrequest, m1_waitrequest}, 64'd3);
        check("rr_rst_valid", {m0_readdatavalid, m1_readdatavalid}, 64'd0);
        @(posedge clk); #1; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t_data = DATA_W'($urandom);
            @(negedge clk);
            check("rr_stray_dropped", {sd_read, m0_readdatavalid, m1_readdatavalid}, 64'd0);
            @(posedge clk); #1;
        end
        t_rdv = 1'b0;
        m_last = 1; m_consec = 0;
        mon_en = 1'b1; slave_en = 1'b1;
        items0.push_back('{ADDR_W'(32'h300), BURST_W'(3)});
        items1.push_back('{ADDR_W'(32'h340), BURST_W'(3)});
        run_phase(1'b0);

        // Randomized traffic.
        for (int ph = 0; ph < 12; ph++) begin
            int n0, n1;
            n0 = int'($urandom_range(0, 4));
            n1 = int'($urandom_range(0, 4));
            for (int i = 0; i < n0; i++)
                items0.push_back('{ADDR_W'($urandom), BURST_W'($urandom_range(0, 16))});
            for (int i = 0; i < n1; i++)
                items1.push_back('{ADDR_W'($urandom), BURST_W'($urandom_range(0, 16))});
            run_phase(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_read_arbiter.md
# sdram_read_arbiter

Two-port Avalon-MM burst-read arbiter sharing the single SDRAM master port between the VGA background fetcher (port 0) and the sprite fetcher (port 1). Grants one burst at a time, forwards the winning command to SDRAM, and routes returning read beats to the owner. Port 0 is favoured while its line FIFO is running low, but a consecutive-grant cap prevents sprite starvation. Sits between both fetch masters and the SDRAM controller slave.

## Interface
- ADDR_W, 30, byte address width
- DATA_W, 16, read data width
- BURST_W, 5, burstcount width (max burst 16)
- M0_MAX_CONSEC, 4, max back-to-back port-0 grants while port 1 is pending
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_read, m1_read  in  1  burst read request, held until accepted
- m0_address, m1_address  in  ADDR_W  burst start address
- m0_burstcount, m1_burstcount  in  BURST_W  beats requested; 0 is treated as 1
- m0_urgent  in  1  port-0 FIFO below refill threshold
- m0_waitrequest, m1_waitrequest  out  1  low only in the cycle the port's command is accepted
- m0_readdatavalid, m1_readdatavalid  out  1  beat valid for that port
- m0_readdata, m1_readdata  out  DATA_W  equal to sd_readdata
- sd_read, sd_chipselect, sd_beginbursttransfer  out  1  command strobes to SDRAM
- sd_address  out  ADDR_W; sd_burstcount  out  BURST_W; sd_byteenable  out  2  fixed 2'b11
- sd_waitrequest, sd_readdatavalid  in  1; sd_readdata  in  DATA_W

## Operation
- States: IDLE, ISSUE, DATA. One burst outstanding at a time.
- IDLE: pick winner among asserted mN_read; latch grant, address, burstcount (0→1); go ISSUE. No request → stay.
- Pick rule, in order: only one requesting → it; both and m0_urgent and consec_cnt < M0_MAX_CONSEC → port 0; both otherwise → port opposite last_grant (round-robin).
- consec_cnt: +1 on each port-0 grant while m1_read is high; cleared on any port-1 grant or when port 0 is granted with m1_read low (then set to 1). Saturates at M0_MAX_CONSEC.
- ISSUE: sd_read = sd_chipselect = 1, sd_address/sd_burstcount from latches; sd_beginbursttransfer = 1 only in the first ISSUE cycle. Hold while sd_waitrequest. On !sd_waitrequest: pulse granted mN_waitrequest low, load beat_cnt = burstcount, go DATA.
- DATA: each sd_readdatavalid drives mN_readdatavalid of the owner and decrements beat_cnt; at beat_cnt = 1 with valid → IDLE, update last_grant.
- sd_readdatavalid outside DATA is dropped (never forwarded).
- Requester must not change address/burstcount while its read is high and waitrequest high; the arbiter samples them only in IDLE.

## Timing
- Reset values: sd_read, sd_chipselect, sd_beginbursttransfer = 0; sd_address = 0; sd_burstcount = 0; sd_byteenable = 2'b11; m0/m1_waitrequest = 1; m0/m1_readdatavalid = 0; state IDLE, last_grant = port 1 (so port 0 wins first tie), consec_cnt = 0, beat_cnt = 0.
- Request seen in IDLE at cycle t → command on sd_* at t+1; accepted at first cycle with sd_waitrequest low.
- Readdata routing combinational, zero latency.
- Last beat in cycle t → IDLE at t+1 → next command at t+2 (one-cycle turnaround).
- Reset asserted mid-burst: immediate return to IDLE and reset values; remaining beats from SDRAM are dropped.
- Requester dropping mN_read after grant: burst still completes; beats still forwarded.

## Structure
- Package vga_mem_pkg: ADDR_W, DATA_W, BURST_W, state enum {IDLE, ISSUE, DATA}, port index constants.
- One sub-module natural: arb_pick (combinational winner select from reqs, urgent, consec_cnt, last_grant).

## Test plan
- m1 alone, addr 0x100, burst 8 → one sd command with sd_beginbursttransfer one cycle, 8 beats on m1_readdatavalid only, m0 untouched.
- Both request, no urgent, bursts of 8 → grants alternate 0,1,0,1 after reset.
- Both request continuously, m0_urgent = 1 → grant order 0,0,0,0,1,0,0,0,0,1.
- sd_waitrequest high 5 cycles in ISSUE → sd_read/address held stable, beginbursttransfer only first cycle, mN_waitrequest low exactly one cycle.
- burstcount 0 on m0 → sd_burstcount = 1, single beat, return to IDLE.
- Reset at beat 3 of 8, then stray sd_readdatavalid beats → no mN_readdatavalid, outputs at reset values, next request served normally.
